pqvalue_vec_seq: RTL and testbench
==================================

Name: pqvalue_vec_seq

Overview:
Vector sequencer for the pqvalue modular ALU (mod_add / mod_sub / mod_mul, Kyber or Dilithium reduction).
- On a start command it streams len coefficient pairs from a 2-read/1-write coefficient register file through the combinational ALU and writes the results back.
- Pipeline throughput is one element per cycle.
- Sits between the core-side command interface and the shared ALU and register file.

Parameters:
- ADDR_W, 8, coefficient register-file address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 9, width of the vector-length field; max len = 2^LEN_W-1.
- DATA_W, 23, coefficient width; fixed to match the ALU, not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  command strobe, accepted only in IDLE
- op_i  in  2  01 mod_add, 10 mod_sub, 11 mod_mul, 00 illegal
- red_i  in  1  0 Dilithium (q=8380417), 1 Kyber (q=3329)
- src_a_i  in  ADDR_W  base address of operand vector A
- src_b_i  in  ADDR_W  base address of operand vector B
- dst_i  in  ADDR_W  base address of the result vector
- len_i  in  LEN_W  element count
- hold_i  in  1  blocks issue of new reads; in-flight elements complete
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse coincident with done_o for an illegal op
- rd_en_o  out  1  register-file read strobe
- rd_a_addr_o  out  ADDR_W  read port A address
- rd_b_addr_o  out  ADDR_W  read port B address
- rd_a_data_i  in  DATA_W  port A data, valid the cycle after rd_en_o
- rd_b_data_i  in  DATA_W  port B data, valid the cycle after rd_en_o
- we_o  out  1  write enable
- wr_addr_o  out  ADDR_W  write address
- wr_data_o  out  DATA_W  write data
- alu_a_o  out  DATA_W  ALU operand A
- alu_b_o  out  DATA_W  ALU operand B
- alu_sel_op_o  out  2  ALU op select
- alu_sel_red_o  out  1  ALU reduction select
- alu_res_i  in  DATA_W  combinational ALU result

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal counters and latched command cleared. Reset mid-run aborts immediately, and no further writes occur.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start_i=1 latches op, red, the three bases and len, and asserts busy_o from the next cycle.
  - If op=00 or len=0, go to FIN. No read or write is ever issued.
  - Otherwise go to RUN.
  - start_i in any other state is ignored.
- RUN:
  - Each cycle with hold_i=0, issue rd_en_o=1 with rd_a_addr_o=src_a+i and rd_b_addr_o=src_b+i, then increment i.
  - With hold_i=1, rd_en_o=0 and i is held.
  - After issuing index len-1, go to DRAIN.
- Pipeline:
  - Read issued in cycle t; data returns in t+1.
  - alu_a_o/alu_b_o are driven directly from rd_*_data_i in t+1.
  - alu_res_i is registered at the end of t+1.
  - In cycle t+2: we_o=1, wr_addr_o=dst+i, wr_data_o=registered result.
  - Read-to-write latency is 2 cycles. Per-stage valid bits travel with the element, so holds create bubbles, never losses or duplicates.
- DRAIN: no new reads. Stay until the last write has been issued, then go to FIN.
- FIN:
  - done_o=1 for one cycle; err_o=1 only if op=00. busy_o=0 in this cycle.
  - Return to IDLE. A new start_i is accepted from the following cycle.
- alu_sel_op_o and alu_sel_red_o are the latched values, constant while busy. In IDLE they are 0.
- alu_a_o/alu_b_o are 0 when no valid read data is present.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Overlap: there is no forwarding. A read returns register-file content at the read cycle.
  - dst==src (in-place) is safe.
  - Other overlaps are software's responsibility.
- Timing for len=N with no hold:
  - Reads occur in cycles 1..N after start.
  - Writes occur in cycles 3..N+2.
  - done_o is asserted in cycle N+3.

Test Plan:
- Kyber add: red=1, op=01, len=4, A={3000,1,0,3328}, B={500,2,0,1}, dst=0x40 -> writes {171,3,0,0} to 0x40..0x43 on consecutive cycles; done_o in cycle 7; err_o=0.
- Kyber sub, in place: A={100}, B={200}, dst=src_a -> 3229 written over A; Dilithium mul with len=8 -> each wr_data_o equals the ALU reference-model result, alu_sel_red_o=0 throughout.
- Degenerate commands: len=0 -> done_o one cycle later, no rd_en_o/we_o; op=00 with len=5 -> done_o and err_o pulse together, zero accesses.
- Hold: len=6, hold_i high for 3 cycles after the 2nd read -> exactly 6 writes to ascending addresses, correct data, done_o delayed by 3 cycles.
- Wrap: src_a=0xFE, dst=0xFF, len=3 -> read addresses 0xFE, 0xFF, 0x00; write addresses 0xFF, 0x00, 0x01. start_i while busy -> ignored, command unchanged.
- Reset: assert rst_ni low after 2 writes of a len=8 run -> all outputs 0 immediately, no further we_o; a new command after release completes normally.

Source files
------------

// File: rtl/pqvalue_vec_seq.sv
// Vector sequencer for the pqvalue modular ALU: streams len operand pairs from a
// 2R/1W coefficient register file through the combinational ALU and writes results back.
module pqvalue_vec_seq #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9,
    parameter int DATA_W = 23
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic              red_i,
    input  logic [ADDR_W-1:0] src_a_i,
    input  logic [ADDR_W-1:0] src_b_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              hold_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_a_addr_o,
    output logic [ADDR_W-1:0] rd_b_addr_o,
    input  logic [DATA_W-1:0] rd_a_data_i,
    input  logic [DATA_W-1:0] rd_b_data_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [1:0]        alu_sel_op_o,
    output logic              alu_sel_red_o,
    input  logic [DATA_W-1:0] alu_res_i
);
    // stage 1: read data at ALU inputs; stage 2: registered result at write port
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic              red;
        logic [ADDR_W-1:0] src_a;
        logic [ADDR_W-1:0] src_b;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    state_t            state, state_nxt;
    cmd_t              cmd_q;
    logic [LEN_W-1:0]  rd_idx, wr_idx;
    logic [STAGES:1]   vld_pipe;
    logic [DATA_W-1:0] res_q;
    logic              issue, last_issue;

    assign issue      = (state == RUN) && !hold_i;
    assign last_issue = issue && (rd_idx == cmd_q.len - LEN_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = (op_i == 2'b00 || len_i == '0) ? FIN : RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            // only the final element is left when stage 2 is valid and stage 1 is empty
            DRAIN:   if (vld_pipe[STAGES] && !vld_pipe[1]) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cmd_q    <= '0;
            rd_idx   <= '0;
            wr_idx   <= '0;
            vld_pipe <= '0;
            res_q    <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[STAGES-1:1], issue};
            if (state == IDLE && start_i) begin
                cmd_q  <= '{op: op_i, red: red_i, src_a: src_a_i, src_b: src_b_i,
                            dst: dst_i, len: len_i};
                rd_idx <= '0;
                wr_idx <= '0;
            end else begin
                if (issue)              rd_idx <= rd_idx + LEN_W'(1);
                if (vld_pipe[STAGES])   wr_idx <= wr_idx + LEN_W'(1);
            end
            if (vld_pipe[1]) res_q <= alu_res_i;
        end
    end

    assign busy_o        = (state == RUN) || (state == DRAIN);
    assign done_o        = (state == FIN);
    assign err_o         = (state == FIN) && (cmd_q.op == 2'b00);
    assign alu_sel_op_o  = (state != IDLE) ? cmd_q.op  : 2'b00;
    assign alu_sel_red_o = (state != IDLE) ? cmd_q.red : 1'b0;

    assign rd_en_o     = issue;
    assign rd_a_addr_o = issue ? cmd_q.src_a + ADDR_W'(rd_idx) : '0;
    assign rd_b_addr_o = issue ? cmd_q.src_b + ADDR_W'(rd_idx) : '0;

    assign alu_a_o = vld_pipe[1] ? rd_a_data_i : '0;
    assign alu_b_o = vld_pipe[1] ? rd_b_data_i : '0;

    // writes retire in issue order, so a separate write index tracks dst+i
    assign we_o      = vld_pipe[STAGES];
    assign wr_addr_o = vld_pipe[STAGES] ? cmd_q.dst + ADDR_W'(wr_idx) : '0;
    assign wr_data_o = vld_pipe[STAGES] ? res_q : '0;
endmodule

// File: tb/tb_pqvalue_vec_seq.sv
// Bench for pqvalue_vec_seq: register-file and ALU models, a table of directed
// commands checked against a reference model, plus hand-written corner sequences.
module tb_pqvalue_vec_seq;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;
    localparam int DATA_W = 23;
    localparam logic [DATA_W-1:0] JUNK = 23'h5A5A5;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic start_i = 1'b0, red_i = 1'b0, hold_i = 1'b0;
    logic [1:0] op_i = 2'b00;
    logic [ADDR_W-1:0] src_a_i = '0, src_b_i = '0, dst_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic busy_o, done_o, err_o, rd_en_o, we_o, alu_sel_red_o;
    logic [ADDR_W-1:0] rd_a_addr_o, rd_b_addr_o, wr_addr_o;
    logic [DATA_W-1:0] rd_a_data_i = JUNK, rd_b_data_i = JUNK;
    logic [DATA_W-1:0] wr_data_o, alu_a_o, alu_b_o, alu_res_i;
    logic [1:0] alu_sel_op_o;

    pqvalue_vec_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i), .red_i(red_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .dst_i(dst_i), .len_i(len_i), .hold_i(hold_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_en_o(rd_en_o),
        .rd_a_addr_o(rd_a_addr_o), .rd_b_addr_o(rd_b_addr_o),
        .rd_a_data_i(rd_a_data_i), .rd_b_data_i(rd_b_data_i),
        .we_o(we_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_sel_op_o(alu_sel_op_o),
        .alu_sel_red_o(alu_sel_red_o), .alu_res_i(alu_res_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DATA_W-1:0] alu_ref(input logic [1:0] op, input logic red,
                                                  input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        longint unsigned q, x, y, r;
        q = red ? 64'd3329 : 64'd8380417;
        x = 64'(a);
        y = 64'(b);
        case (op)
            2'b01:   r = (x + y) % q;
            2'b10:   r = (x + q - y) % q;
            2'b11:   r = (x * y) % q;
            default: r = 0;
        endcase
        return r[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] pat(input int i, input int seed, input logic red);
        int q;
        q = red ? 3329 : 8380417;
        return DATA_W'((i * 7919 + seed * 131 + 17) % q);
    endfunction

    always_comb alu_res_i = alu_ref(alu_sel_op_o, alu_sel_red_o, alu_a_o, alu_b_o);

    // register file model: reads return content at the read cycle
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] snap [0:255];
    logic ld_en = 1'b0, fill_en = 1'b0, fill_red = 1'b0;
    logic [7:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    int fill_seed = 0;

    always @(posedge clk_i) begin
        if (rd_en_o) begin
            rd_a_data_i <= mem[rd_a_addr_o];
            rd_b_data_i <= mem[rd_b_addr_o];
        end else begin
            rd_a_data_i <= JUNK;
            rd_b_data_i <= JUNK;
        end
        if (fill_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i, fill_seed, fill_red);
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (we_o) begin
            mem[wr_addr_o] <= wr_data_o;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int seed, input logic red);
        @(posedge clk_i); #1;
        fill_en = 1'b1; fill_seed = seed; fill_red = red;
        @(posedge clk_i); #1;
        fill_en = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk_i); #1;
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk_i); #1;
        ld_en = 1'b0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic       red;
        logic [7:0] src_a;
        logic [7:0] src_b;
        logic [7:0] dst;
        logic [8:0] len;
        int hold_at;
        int hold_n;
        int poke_at;
        int exp_done;
        int seed;
    } vec_t;

    logic [7:0]        rda_q[$], rdb_q[$], wra_q[$];
    logic [DATA_W-1:0] wrd_q[$];
    int                wrc_q[$];
    int   done_cyc;
    logic err_seen, busy_at_done, sel_bad, alu_idle_bad;

    task automatic run_cmd(input vec_t c);
        rda_q.delete(); rdb_q.delete(); wra_q.delete(); wrd_q.delete(); wrc_q.delete();
        done_cyc = -1; err_seen = 1'b0; busy_at_done = 1'b0; sel_bad = 1'b0; alu_idle_bad = 1'b0;
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = c.op; red_i = c.red; src_a_i = c.src_a; src_b_i = c.src_b;
        dst_i = c.dst; len_i = c.len;
        @(posedge clk_i); #1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            hold_i = (c.hold_n > 0) && (cyc >= c.hold_at) && (cyc < c.hold_at + c.hold_n);
            if (cyc == c.poke_at) begin
                start_i = 1'b1; op_i = 2'b10; src_a_i = 8'h77; dst_i = 8'h99; len_i = 9'd1;
            end else begin
                start_i = 1'b0;
            end
            #1;
            if (rd_en_o) begin rda_q.push_back(rd_a_addr_o); rdb_q.push_back(rd_b_addr_o); end
            if (we_o) begin wra_q.push_back(wr_addr_o); wrd_q.push_back(wr_data_o); wrc_q.push_back(cyc); end
            if (busy_o && (alu_sel_op_o != c.op || alu_sel_red_o != c.red)) sel_bad = 1'b1;
            if (done_o) begin
                done_cyc = cyc; err_seen = err_o; busy_at_done = busy_o;
                alu_idle_bad = (alu_a_o != '0) || (alu_b_o != '0);
                break;
            end
            @(posedge clk_i); #1;
        end
        hold_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic check_run(input vec_t c, input string tag);
        int n;
        n = (c.op == 2'b00 || c.len == '0) ? 0 : int'(c.len);
        chk({tag, " done_cycle"}, done_cyc, c.exp_done);
        chk({tag, " err"}, err_seen, (c.op == 2'b00) ? 1 : 0);
        chk({tag, " busy_at_done"}, busy_at_done, 0);
        chk({tag, " alu_in_idle"}, alu_idle_bad, 0);
        chk({tag, " alu_sel"}, sel_bad, 0);
        chk({tag, " write_count"}, wra_q.size(), n);
        chk({tag, " read_count"}, rda_q.size(), n);
        if (wra_q.size() == n && rda_q.size() == n) begin
            for (int j = 0; j < n; j++) begin
                logic [7:0] ea, eb, ed;
                ea = c.src_a + 8'(j);
                eb = c.src_b + 8'(j);
                ed = c.dst + 8'(j);
                chk({tag, " rd_a_addr"}, rda_q[j], ea);
                chk({tag, " rd_b_addr"}, rdb_q[j], eb);
                chk({tag, " wr_addr"}, wra_q[j], ed);
                chk({tag, " wr_data"}, wrd_q[j], alu_ref(c.op, c.red, snap[ea], snap[eb]));
            end
            if (n > 0) begin
                chk({tag, " first_wr_cycle"}, wrc_q[0], 3);
                chk({tag, " last_wr_cycle"}, wrc_q[n-1], c.exp_done - 1);
            end
        end
    endtask

    vec_t tbl[7];
    vec_t kc, rc;
    logic [DATA_W-1:0] kexp[4];
    int wr_seen, late_wr;

    initial begin
        //          op     red   src_a  src_b  dst    len  hold_at hold_n poke exp_done seed
        tbl[0] = '{2'b11, 1'b0, 8'h10, 8'h20, 8'h80, 9'd8, 0, 0, 0, 11, 3};  // Dilithium mul
        tbl[1] = '{2'b01, 1'b1, 8'h00, 8'h10, 8'h30, 9'd0, 0, 0, 0,  1, 4};  // len=0
        tbl[2] = '{2'b00, 1'b1, 8'h00, 8'h10, 8'h30, 9'd5, 0, 0, 0,  1, 5};  // illegal op
        tbl[3] = '{2'b10, 1'b0, 8'h30, 8'h50, 8'h90, 9'd6, 3, 3, 0, 12, 6};  // hold bubbles
        tbl[4] = '{2'b01, 1'b1, 8'hFE, 8'h05, 8'hFF, 9'd3, 0, 0, 0,  6, 7};  // address wrap
        tbl[5] = '{2'b11, 1'b1, 8'h00, 8'h08, 8'hA0, 9'd3, 0, 0, 2,  6, 8};  // start while busy
        tbl[6] = '{2'b10, 1'b1, 8'h40, 8'h48, 8'h40, 9'd1, 0, 0, 0,  4, 9};  // in place, len=1

        #12;
        chk("reset_outputs", |{busy_o, done_o, err_o, rd_en_o, rd_a_addr_o, rd_b_addr_o, we_o,
                               wr_addr_o, wr_data_o, alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Kyber add with hand-computed results
        fill(1, 1'b1);
        poke(8'h00, 23'd3000); poke(8'h01, 23'd1); poke(8'h02, 23'd0); poke(8'h03, 23'd3328);
        poke(8'h10, 23'd500);  poke(8'h11, 23'd2); poke(8'h12, 23'd0); poke(8'h13, 23'd1);
        kc = '{2'b01, 1'b1, 8'h00, 8'h10, 8'h40, 9'd4, 0, 0, 0, 7, 1};
        kexp[0] = 23'd171; kexp[1] = 23'd3; kexp[2] = 23'd0; kexp[3] = 23'd0;
        run_cmd(kc);
        check_run(kc, "kyber_add");
        if (wrd_q.size() == 4)
            for (int j = 0; j < 4; j++) chk("kyber_add hand_data", wrd_q[j], kexp[j]);

        // Kyber sub in place: 100 - 200 mod 3329
        fill(2, 1'b1);
        poke(8'h60, 23'd100); poke(8'h61, 23'd200);
        kc = '{2'b10, 1'b1, 8'h60, 8'h61, 8'h60, 9'd1, 0, 0, 0, 4, 2};
        run_cmd(kc);
        check_run(kc, "kyber_sub_inplace");
        chk("kyber_sub_inplace mem", mem[8'h60], 3229);

        for (int t = 0; t < 7; t++) begin
            fill(tbl[t].seed, tbl[t].red);
            run_cmd(tbl[t]);
            check_run(tbl[t], $sformatf("tbl%0d", t));
        end

        // reset in the middle of a len=8 run, after the second write
        fill(11, 1'b1);
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        rc = '{2'b01, 1'b1, 8'h00, 8'h20, 8'hC0, 9'd8, 0, 0, 0, 11, 11};
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = rc.op; red_i = rc.red; src_a_i = rc.src_a; src_b_i = rc.src_b;
        dst_i = rc.dst; len_i = rc.len;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wr_seen = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            #1;
            if (we_o) wr_seen++;
            if (wr_seen == 2) break;
            @(posedge clk_i); #1;
        end
        chk("reset_seq writes_before", wr_seen, 2);
        rst_ni = 1'b0;
        #1;
        chk("reset_seq outputs", |{busy_o, done_o, err_o, rd_en_o, rd_a_addr_o, rd_b_addr_o, we_o,
                                   wr_addr_o, wr_data_o, alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o}, 0);
        late_wr = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            if (we_o) late_wr++;
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i); #1;
            if (we_o || busy_o) late_wr++;
        end
        chk("reset_seq no_activity", late_wr, 0);
        chk("reset_seq mem_untouched", mem[8'hC2], snap[8'hC2]);

        // a fresh command after reset completes normally
        fill(rc.seed, rc.red);
        run_cmd(rc);
        check_run(rc, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
